// File: rtl/demux_stream_nch_pkg.sv
// Shared helpers for the demux_stream_nch slice: width math and select-range queries.
// Optional feature macro used by this slice: DEMUX_SEL_ERR_EN.
package demux_stream_nch_pkg;

  // Ceiling log2, never below 1 so a pointer always has at least one bit.
  function automatic int unsigned clog2_u(input int unsigned v);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // True when a select of sel_w bits can name channels that do not exist.
  function automatic bit has_spare_codes(input int unsigned n, input int unsigned sel_w);
    return (64'(1) << sel_w) > 64'(n);
  endfunction

endpackage

// File: rtl/demux_stream_nch_rr_ptr.sv
// Modulo-N up-counter with enable and synchronous active-low reset.
module demux_stream_nch_rr_ptr
  import demux_stream_nch_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned PTR_W = clog2_u(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [PTR_W-1:0] ptr
);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  // Advance on enable, wrapping from N-1 back to 0.
  always_comb begin
    ptr_d = ptr_q;
    if (en) begin
      if (ptr_q == PTR_W'(N - 1)) ptr_d = '0;
      else                        ptr_d = ptr_q + PTR_W'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/demux_stream_nch.sv
// Registered 1-to-N stream demux with per-channel valid/ready and round-robin mode.
// Define DEMUX_SEL_ERR_EN to drop out-of-range selects and pulse err; otherwise they clamp to N-1.
module demux_stream_nch
  import demux_stream_nch_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned W     = 8,
  parameter int unsigned SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     m_data,
  input  logic             m_valid,
  output logic             m_ready,
  input  logic [SEL_W-1:0] sel,
  input  logic             auto_mode,
  output logic [N*W-1:0]   y_data,
  output logic [N-1:0]     y_valid,
  input  logic [N-1:0]     y_ready
`ifdef DEMUX_SEL_ERR_EN
  ,
  output logic             err
`endif
);

  logic             hold_valid_q, hold_valid_d;
  logic [W-1:0]     hold_data_q,  hold_data_d;
  logic [SEL_W-1:0] hold_ch_q,    hold_ch_d;
`ifdef DEMUX_SEL_ERR_EN
  logic             err_q, err_d;
`endif

  logic             ch_ready_c;
  logic             accept_c;
  logic             drain_c;
  logic             in_range_c;
  logic [SEL_W-1:0] rr_ptr_c;
  logic [SEL_W-1:0] dest_raw_c;
  logic [SEL_W-1:0] dest_c;

  // Round-robin destination pointer, advanced only by auto-mode accepts.
  demux_stream_nch_rr_ptr #(
    .N     (N),
    .PTR_W (SEL_W)
  ) u_rr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (accept_c && auto_mode),
    .ptr   (rr_ptr_c)
  );

  // Ready of the channel currently holding the beat; other channels' ready is ignored.
  always_comb begin
    ch_ready_c = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (hold_ch_q == SEL_W'(i)) ch_ready_c = y_ready[i];
    end
  end

  assign m_ready    = !hold_valid_q || ch_ready_c;
  assign accept_c   = m_valid && m_ready;
  assign drain_c    = hold_valid_q && ch_ready_c;
  assign dest_raw_c = auto_mode ? rr_ptr_c : sel;

  // Range check only exists when the select can encode missing channels.
  generate
    if (has_spare_codes(N, SEL_W)) begin : g_range
      assign in_range_c = (32'(dest_raw_c) < 32'(N));
    end else begin : g_full
      assign in_range_c = 1'b1;
    end
  endgenerate

  assign dest_c = in_range_c ? dest_raw_c : SEL_W'(N - 1);

  // Holding register update: drain empties it, an accepted beat refills it.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    hold_ch_d    = hold_ch_q;
`ifdef DEMUX_SEL_ERR_EN
    err_d        = 1'b0;
`endif
    if (drain_c) hold_valid_d = 1'b0;
`ifdef DEMUX_SEL_ERR_EN
    if (accept_c && in_range_c) begin
      hold_valid_d = 1'b1;
      hold_data_d  = m_data;
      hold_ch_d    = dest_c;
    end
    if (accept_c && !in_range_c) err_d = 1'b1;
`else
    if (accept_c) begin
      hold_valid_d = 1'b1;
      hold_data_d  = m_data;
      hold_ch_d    = dest_c;
    end
`endif
  end

  // State registers; a beat held at reset is discarded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      hold_ch_q    <= '0;
`ifdef DEMUX_SEL_ERR_EN
      err_q        <= 1'b0;
`endif
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      hold_ch_q    <= hold_ch_d;
`ifdef DEMUX_SEL_ERR_EN
      err_q        <= err_d;
`endif
    end
  end

  // One-hot decode of the held beat onto its lane; idle lanes drive zero.
  always_comb begin
    y_valid = '0;
    y_data  = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (hold_valid_q && (hold_ch_q == SEL_W'(i))) begin
        y_valid[i]         = 1'b1;
        y_data[i*W +: W]   = hold_data_q;
      end
    end
  end

`ifdef DEMUX_SEL_ERR_EN
  assign err = err_q;
`endif

endmodule
